fsm_eg_stim_driver: RTL and testbench

Transmit-side companion to the two-input a/b control FSM (states S0/S1/S2, Moore output y1, Mealy output y0). It accepts a queue of target-state commands and generates the a/b input sequence that steers the FSM into each target in turn. It keeps a shadow copy of the FSM state and, when checking is compiled in, compares the FSM's y0/y1 against the shadow every cycle. It sits between a command source (test sequencer or host register) and the FSM.

---
 rtl/fsm_eg_stim_driver.sv | 146 ++++++++++++++
 tb/tb_fsm_eg_stim_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_eg_stim_driver.sv
// Command-queue driver that steers the two-input a/b FSM (S0/S1/S2) to each queued target state.
// Define FSM_EG_DRV_CHECK_EN to compile in the y0/y1 shadow checker (err, err_count).
module fsm_eg_stim_driver #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_state,
    output logic             a,
    output logic             b,
    input  logic             y0,
    input  logic             y1,
    output logic             busy,
    output logic             cmd_done,
    output logic             bad_cmd,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } state_t;

    state_t           shadow_q, shadow_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             bad_cmd_q, bad_cmd_d;
    logic [1:0]       mem_q [DEPTH];

    logic             empty;
    logic             handshake;
    logic             push;
    logic             pop;
    logic [1:0]       head;

    assign empty     = (count_q == '0);
    assign cmd_ready = (count_q != (PTR_W+1)'(DEPTH));
    assign busy      = !empty;
    assign head      = mem_q[rd_ptr_q];
    assign handshake = cmd_valid & cmd_ready;
    // Illegal targets complete the handshake but are never stored.
    assign push      = handshake & (cmd_state != 2'b11);
    assign cmd_done  = pop;
    assign bad_cmd   = bad_cmd_q;

    // a/b depend only on registered shadow and FIFO head, so no y0/y1 loop can form.
    always_comb begin
        a   = 1'b0;
        b   = 1'b0;
        pop = 1'b0;
        if (!empty) begin
            if (shadow_q == state_t'(head)) begin
                pop = 1'b1;
            end else begin
                case (shadow_q)
                    S0: begin
                        a = 1'b1;
                        b = (head == 2'b10);
                    end
                    S1:      a = 1'b1;
                    default: a = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        case (shadow_q)
            S0:      shadow_d = a ? (b ? S2 : S1) : S0;
            S1:      shadow_d = a ? S0 : S1;
            default: shadow_d = S0;
        endcase
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        bad_cmd_d = bad_cmd_q | (handshake & (cmd_state == 2'b11));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q  <= S0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            bad_cmd_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            bad_cmd_q <= bad_cmd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_state;
        end
    end

`ifdef FSM_EG_DRV_CHECK_EN
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             exp_y0;
    logic             exp_y1;
    logic             mismatch;

    always_comb begin
        exp_y1      = (shadow_q == S0) | (shadow_q == S1);
        exp_y0      = (shadow_q == S0) & a & b;
        mismatch    = (y1 != exp_y1) | (y0 != exp_y0);
        err_d       = err_q | mismatch;
        err_count_d = err_count_q;
        if (mismatch && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign err       = err_q;
    assign err_count = err_count_q;
`else
    logic unused_y;
    assign unused_y  = y0 ^ y1;
    assign err       = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_fsm_eg_stim_driver.sv
// Randomized bench for fsm_eg_stim_driver: a stand-in a/b FSM closes the loop and a
// queue-based route model predicts a/b, cmd_done, flags and per-command latency.
module tb_fsm_eg_stim_driver;
    localparam int DEPTH = 4;
    localparam int ERR_W = 3;
`ifdef FSM_EG_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_state;
    logic             a, b, y0, y1;
    logic             busy, cmd_done, bad_cmd, err;
    logic [ERR_W-1:0] err_count;

    always #5 clk = ~clk;

    fsm_eg_stim_driver #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_state (cmd_state),
        .a         (a),
        .b         (b),
        .y0        (y0),
        .y1        (y1),
        .busy      (busy),
        .cmd_done  (cmd_done),
        .bad_cmd   (bad_cmd),
        .err       (err),
        .err_count (err_count)
    );

    // Stand-in for the controlled FSM, with fault injection on its outputs.
    logic [1:0] fsm_q;
    logic       force_y1_lo, force_y0_hi;
    always @(posedge clk or posedge reset) begin
        if (reset) fsm_q <= 2'd0;
        else case (fsm_q)
            2'd0:    fsm_q <= a ? (b ? 2'd2 : 2'd1) : 2'd0;
            2'd1:    fsm_q <= a ? 2'd0 : 2'd1;
            default: fsm_q <= 2'd0;
        endcase
    end
    assign y1 = force_y1_lo ? 1'b0 : (fsm_q != 2'd2);
    assign y0 = force_y0_hi | ((fsm_q == 2'd0) & a & b);

    int checks, errors;
    int q[$];
    int ms, age, head_from, m_cnt, dut_done;
    bit m_bad, m_err, last_acc, full_seen;
    int lat [3][3] = '{'{1, 2, 2}, '{2, 1, 3}, '{2, 3, 1}};

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        if (obs != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle();
        bit ea, eb, ed, mis;
        int n;
        #1;
        ea = 0; eb = 0; ed = 0;
        n = q.size();
        if (n != 0) begin
            if (ms == q[0]) ed = 1;
            else if (ms == 0) begin ea = 1; eb = (q[0] == 2); end
            else if (ms == 1) ea = 1;
        end
        chk("a", a, ea);
        chk("b", b, eb);
        chk("cmd_done", cmd_done, ed);
        chk("busy", busy, n != 0);
        chk("cmd_ready", cmd_ready, n < DEPTH);
        chk("bad_cmd", bad_cmd, m_bad);
        chk("err", err, CHK ? int'(m_err) : 0);
        chk("err_count", err_count, CHK ? m_cnt : 0);
        if (!cmd_ready) full_seen = 1;
        if (cmd_done) dut_done++;
        mis = (y1 != (ms != 2)) || (y0 != (ms == 0 && ea && eb));
        if (mis) begin
            m_err = 1;
            if (m_cnt < (1 << ERR_W) - 1) m_cnt++;
        end
        last_acc = cmd_valid && (n < DEPTH);
        if (n != 0) begin
            if (age == 0) head_from = ms;
            if (ed) begin
                chk("latency", age + 1, lat[head_from][q[0]]);
                void'(q.pop_front());
                age = 0;
            end else begin
                age++;
            end
        end
        if (last_acc) begin
            if (cmd_state == 2'd3) m_bad = 1;
            else q.push_back(int'(cmd_state));
        end
        if (ms == 0)      ms = ea ? (eb ? 2 : 1) : 0;
        else if (ms == 1) ms = ea ? 0 : 1;
        else              ms = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_bad", bad_cmd, 0);
        chk("rst_err", err, 0);
        chk("rst_err_count", err_count, 0);
        q.delete();
        ms = 0; age = 0; m_bad = 0; m_err = 0; m_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic offer(input int s);
        cmd_valid = 1'b1;
        cmd_state = 2'(s);
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst [8] = '{1, 0, 2, 0, 2, 1, 2, 2};
        int i, n, d0;
        reset = 1'b0; cmd_valid = 1'b0; cmd_state = 2'd0;
        force_y1_lo = 1'b0; force_y0_hi = 1'b0;
        checks = 0; errors = 0; dut_done = 0; full_seen = 0;
        @(negedge clk);
        do_reset();

        // S0 -> S1: (1,0) then retire
        offer(1);
        #1 chk("t1_ab0", {a, b}, 2); chk("t1_y1a", y1, 1);
        cycle();
        #1 chk("t1_ab1", {a, b}, 0); chk("t1_done", cmd_done, 1); chk("t1_y1b", y1, 1);
        cycle();
        idle(2);

        // S1 -> S2 via S0: (1,0),(1,1),(0,0)
        offer(2);
        #1 chk("t2_ab0", {a, b}, 2);
        cycle();
        #1 chk("t2_ab1", {a, b}, 3); chk("t2_y0", y0, 1);
        cycle();
        #1 chk("t2_ab2", {a, b}, 0); chk("t2_done", cmd_done, 1);
        cycle();
        idle(2);

        // Back-to-back burst fills the FIFO
        d0 = dut_done; full_seen = 0; i = 0; n = 0;
        while (i < 8 && n < 100) begin
            cmd_valid = 1'b1;
            cmd_state = 2'(burst[i]);
            cycle();
            if (last_acc) i++;
            n++;
        end
        cmd_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 60) begin cycle(); n++; end
        #1 chk("burst_busy", busy, 0);
        chk("burst_full_seen", full_seen, 1);
        chk("burst_done", dut_done - d0, 8);
        cycle();

        // Illegal command
        offer(3);
        #1 chk("bad_sticky", bad_cmd, 1); chk("bad_busy", busy, 0); chk("bad_ab", {a, b}, 0);
        cycle();
        idle(2);

        // y1 held low for 3 cycles while idle in S0
        force_y1_lo = 1'b1;
        repeat (3) cycle();
        force_y1_lo = 1'b0;
        #1 chk("force_err", err, CHK ? 1 : 0); chk("force_err_count", err_count, CHK ? 3 : 0);
        cycle();

        // Reset while shadow is S2 with two commands queued
        do_reset();
        offer(2);
        offer(1);
        cmd_valid = 1'b1; cmd_state = 2'd0;
        do_reset();
        offer(1);
        idle(4);

        // Randomized phase, including output faults and occasional reset
        repeat (2000) begin
            cmd_valid   = ($urandom_range(0, 99) < 60);
            cmd_state   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            force_y1_lo = ($urandom_range(0, 99) < 3);
            force_y0_hi = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle();
        end
        force_y1_lo = 1'b0; force_y0_hi = 1'b0; cmd_valid = 1'b0;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
